conv_frame_bridge: RTL and testbench

Stream-side front/back end for the 9x9 Sobel convolution engine. Accepts a frame of 81 8-bit pixels on a valid/ready input stream, packs them into the engine's flattened 648-bit input matrix, pulses the engine's start, and waits for a fresh done. It then captures the 648-bit result and serializes it back out as 81 bytes on a valid/ready output stream. It sits between the pixel source/sink and the convolution engine, and owns the engine's start/done handshake.

---
 rtl/conv_frame_bridge.sv | 225 ++++++++++++++++++++++
 tb/tb_conv_frame_bridge.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_bridge.sv
// conv_frame_bridge
//
// Stream front/back end for the NxN Sobel convolution engine.
// A frame of N*N pixels arrives on a valid/ready stream. It is packed into the
// engine's flattened input matrix, and the engine is kicked with a one-cycle
// start. The bridge then waits for a fresh rising edge of done, captures the
// result matrix and replays it as N*N bytes on a valid/ready output stream.
//
// Optional build macro: CONV_BRIDGE_TIMEOUT_EN
//   When defined, a watchdog aborts WAIT after TIMEOUT cycles without a done
//   edge. It pulses err_timeout and returns to LOAD without producing output.
//   When undefined, WAIT is unbounded and err_timeout is constant 0.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   s_valid/s_ready pixel input handshake; s_data pixel, s_last end marker
//   conv_in         packed matrix to the engine, pixel k at [k*W +: W]
//   conv_start      one-cycle start pulse to the engine
//   conv_out        engine result matrix, same packing as conv_in
//   conv_done       engine done level
//   m_valid/m_ready byte output handshake; m_data byte, m_last final byte
//   busy            high in KICK, WAIT and DRAIN
//   err_len         one-cycle pulse when s_last disagrees with the pixel count
//   err_timeout     one-cycle pulse on watchdog expiry
module conv_frame_bridge #(
    parameter int N       = 9,
    parameter int W       = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    input  logic [W-1:0]       s_data,
    input  logic               s_last,
    output logic               s_ready,
    output logic [N*N*W-1:0]   conv_in,
    output logic               conv_start,
    input  logic [N*N*W-1:0]   conv_out,
    input  logic               conv_done,
    output logic               m_valid,
    output logic [W-1:0]       m_data,
    output logic               m_last,
    input  logic               m_ready,
    output logic               busy,
    output logic               err_len,
    output logic               err_timeout
);

    localparam int         NP       = N * N;
    localparam logic [6:0] LAST_IDX = 7'(NP - 1);

    typedef enum logic [1:0] {ST_LOAD, ST_KICK, ST_WAIT, ST_DRAIN} state_t;

    state_t     state_reg;
    logic [6:0] idx_reg;
    logic [6:0] idx_inc;
    logic       s_ready_reg;
    logic       conv_start_reg;
    logic       m_valid_reg;
    logic       m_last_reg;
    logic [W-1:0] m_data_reg;
    logic       busy_reg;
    logic       err_len_reg;
    logic       err_timeout_reg;
    logic       done_q_reg;

    logic [W-1:0] in_mem  [NP];
    logic [W-1:0] res_mem [NP];

    logic s_hs;
    logic m_hs;
    logic done_edge;
    logic wd_expire;

    assign s_hs      = (state_reg == ST_LOAD) && s_valid && s_ready_reg;
    assign m_hs      = (state_reg == ST_DRAIN) && m_valid_reg && m_ready;
    // Only a fresh rise counts: a done level left over from the previous
    // frame must fall and rise again before it is accepted.
    assign done_edge = conv_done && !done_q_reg;
    assign idx_inc   = idx_reg + 7'd1;

    // Per-pixel input and result storage. Input slots are only written in
    // LOAD, so conv_in stays stable from KICK until the next frame loads.
    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_pix
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    in_mem[gi] <= '0;
                end else if (s_hs && (idx_reg == 7'(gi))) begin
                    in_mem[gi] <= s_data;
                end
            end

            always_ff @(posedge clk) begin
                if ((state_reg == ST_WAIT) && done_edge) begin
                    res_mem[gi] <= conv_out[gi*W +: W];
                end
            end

            assign conv_in[gi*W +: W] = in_mem[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q_reg <= 1'b0;
        end else begin
            done_q_reg <= conv_done;
        end
    end

`ifdef CONV_BRIDGE_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] wd_reg;

    // Cleared while in KICK so the count starts from zero on WAIT entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_reg <= '0;
        end else if (state_reg == ST_KICK) begin
            wd_reg <= '0;
        end else if (state_reg == ST_WAIT) begin
            wd_reg <= wd_reg + WDW'(1);
        end
    end

    assign wd_expire = (wd_reg == WDW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign wd_expire      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_LOAD;
            idx_reg         <= '0;
            s_ready_reg     <= 1'b0;
            conv_start_reg  <= 1'b0;
            m_valid_reg     <= 1'b0;
            m_last_reg      <= 1'b0;
            m_data_reg      <= '0;
            busy_reg        <= 1'b0;
            err_len_reg     <= 1'b0;
            err_timeout_reg <= 1'b0;
        end else begin
            conv_start_reg  <= 1'b0;
            err_len_reg     <= 1'b0;
            err_timeout_reg <= 1'b0;
            case (state_reg)
                ST_LOAD: begin
                    // Also raises s_ready on the first edge after reset.
                    s_ready_reg <= 1'b1;
                    if (s_hs) begin
                        // Frame length is fixed; s_last is only cross-checked.
                        err_len_reg <= s_last ^ (idx_reg == LAST_IDX);
                        if (idx_reg == LAST_IDX) begin
                            state_reg      <= ST_KICK;
                            idx_reg        <= '0;
                            s_ready_reg    <= 1'b0;
                            conv_start_reg <= 1'b1;
                            busy_reg       <= 1'b1;
                        end else begin
                            idx_reg <= idx_inc;
                        end
                    end
                end
                ST_KICK: begin
                    state_reg <= ST_WAIT;
                    idx_reg   <= '0;
                end
                ST_WAIT: begin
                    if (done_edge) begin
                        state_reg   <= ST_DRAIN;
                        idx_reg     <= '0;
                        m_valid_reg <= 1'b1;
                        // First byte comes straight from the engine since the
                        // buffer is being written on this same edge.
                        m_data_reg  <= conv_out[W-1:0];
                        m_last_reg  <= (LAST_IDX == 7'd0);
                    end else if (wd_expire) begin
                        err_timeout_reg <= 1'b1;
                        state_reg       <= ST_LOAD;
                        idx_reg         <= '0;
                        s_ready_reg     <= 1'b1;
                        busy_reg        <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (m_hs) begin
                        if (idx_reg == LAST_IDX) begin
                            state_reg   <= ST_LOAD;
                            idx_reg     <= '0;
                            m_valid_reg <= 1'b0;
                            m_last_reg  <= 1'b0;
                            busy_reg    <= 1'b0;
                            s_ready_reg <= 1'b1;
                        end else begin
                            // Prefetch the next byte so data tracks idx with
                            // no bubble; on a stall nothing here changes.
                            idx_reg    <= idx_inc;
                            m_data_reg <= res_mem[idx_inc];
                            m_last_reg <= (idx_inc == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_reg <= ST_LOAD;
                end
            endcase
        end
    end

    assign s_ready     = s_ready_reg;
    assign conv_start  = conv_start_reg;
    assign m_valid     = m_valid_reg;
    assign m_data      = m_data_reg;
    assign m_last      = m_last_reg;
    assign busy        = busy_reg;
    assign err_len     = err_len_reg;
    assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_conv_frame_bridge.sv
// tb_conv_frame_bridge
//
// Directed bench for conv_frame_bridge. A stub engine answers each start with
// conv_out = ~conv_in after a programmable delay. Expected output bytes are
// queued as pixels are accepted and popped by a monitor on output handshakes.
// Build with CONV_BRIDGE_TIMEOUT_EN to exercise the watchdog (TIMEOUT=100).
module tb_conv_frame_bridge;

    localparam int N  = 9;
    localparam int W  = 8;
    localparam int NP = N * N;
    localparam int TO = 100;

    logic             clk = 1'b0;
    logic             rst;
    logic             s_valid;
    logic [W-1:0]     s_data;
    logic             s_last;
    logic             s_ready;
    logic [NP*W-1:0]  conv_in;
    logic             conv_start;
    logic [NP*W-1:0]  conv_out;
    logic             conv_done;
    logic             m_valid;
    logic [W-1:0]     m_data;
    logic             m_last;
    logic             m_ready = 1'b1;
    logic             busy;
    logic             err_len;
    logic             err_timeout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [W-1:0] exp_q[$];
    int   out_cnt     = 0;
    int   first_cyc   = 0;
    int   last_cyc    = 0;
    int   rise_cyc    = -100;
    int   start_cnt   = 0;
    int   errlen_cnt  = 0;
    int   start_exp   = 0;
    int   errlen_exp  = 0;
    int   hs_cyc      = 0;
    bit   bp_mode     = 1'b0;
    bit   stub_never  = 1'b0;
    int   stub_delay  = 50;
    logic [3:0] bp_pat = 4'b1001;

    conv_frame_bridge #(.N(N), .W(W), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .conv_in     (conv_in),
        .conv_start  (conv_start),
        .conv_out    (conv_out),
        .conv_done   (conv_done),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .busy        (busy),
        .err_len     (err_len),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (conv_start) start_cnt <= start_cnt + 1;
        if (err_len) errlen_cnt <= errlen_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stub engine: drops done one cycle after start, raises it stub_delay
    // cycles later with the inverted input matrix.
    initial begin : stub
        logic [NP*W-1:0] snap;
        conv_done = 1'b0;
        conv_out  = '0;
        forever begin
            @(negedge clk);
            if (conv_start) begin
                snap = conv_in;
                @(negedge clk);
                conv_done = 1'b0;
                if (!stub_never) begin
                    repeat (stub_delay) @(negedge clk);
                    conv_out  = ~snap;
                    conv_done = 1'b1;
                    rise_cyc  = cyc;
                end
            end
        end
    end

    // Output monitor: drives m_ready, checks ordering, stalls and latency.
    initial begin : mon
        logic       prev_mv;
        logic       stalled;
        logic [W-1:0] held_d;
        logic       held_l;
        logic [W-1:0] e;
        int         ph;
        prev_mv = 1'b0;
        stalled = 1'b0;
        held_d  = '0;
        held_l  = 1'b0;
        ph      = 0;
        forever begin
            @(negedge clk);
            m_ready = bp_mode ? bp_pat[ph % 4] : 1'b1;
            ph++;
            if (stalled) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data", 32'(m_data), 32'(held_d));
                chk("stall_last", 32'(m_last), 32'(held_l));
            end
            if (m_valid && !prev_mv) chk("out_latency", cyc, rise_cyc + 1);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_data", 32'(m_data), 32'(e));
                    chk("m_last", 32'(m_last), 32'(out_cnt == NP - 1));
                end
                if (out_cnt == 0) first_cyc = cyc;
                if (out_cnt == NP - 1) last_cyc = cyc;
                out_cnt++;
            end
            stalled = m_valid && !m_ready;
            held_d  = m_data;
            held_l  = m_last;
            prev_mv = m_valid;
        end
    end

    task automatic check_idle_zero(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_conv_start"}, 32'(conv_start), 32'd0);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_last"}, 32'(m_last), 32'd0);
        chk({tag, "_m_data"}, 32'(m_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err_len"}, 32'(err_len), 32'd0);
        chk({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
        chk({tag, "_conv_in"}, 32'(|conv_in), 32'd0);
    endtask

    // Feed one frame; call at a negedge. bad_len moves s_last to pixel 40.
    task automatic send_frame(input logic [7:0] base, input logic [7:0] mul,
                              input int gap, input bit bad_len);
        logic [W-1:0] pix [NP];
        logic         lst;
        int           n;
        for (int k = 0; k < NP; k++) begin
            if (k > 0) begin
                for (int g = 0; g < gap; g++) begin
                    s_valid = 1'b0;
                    @(negedge clk);
                end
            end
            pix[k]  = base + mul * 8'(k);
            lst     = bad_len ? (k == 40) : (k == NP - 1);
            s_valid = 1'b1;
            s_data  = pix[k];
            s_last  = lst;
            n = 0;
            while (!s_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) chk("s_ready_wait", 32'd0, 32'd1);
            exp_q.push_back(~pix[k]);
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
            chk("err_len", 32'(err_len), 32'(lst != (k == NP - 1)));
            if (k == NP - 1) begin
                hs_cyc = cyc;
                chk("start_pulse", 32'(conv_start), 32'd1);
                chk("s_ready_drop", 32'(s_ready), 32'd0);
                chk("busy_kick", 32'(busy), 32'd1);
                for (int j = 0; j < NP; j++)
                    chk("conv_in_byte", 32'(conv_in[j*W +: W]), 32'(pix[j]));
            end
        end
        start_exp++;
        if (bad_len) errlen_exp += 2;
        @(negedge clk);
        chk("start_single", 32'(conv_start), 32'd0);
        chk("busy_wait", 32'(busy), 32'd1);
    endtask

    task automatic wait_drain(input int fid);
        int n;
        n = 0;
        while (out_cnt < NP && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 3000) chk("drain_timeout", 32'(out_cnt), 32'(NP));
        @(negedge clk);
        chk("turnaround_s_ready", 32'(s_ready), 32'd1);
        chk("end_m_valid", 32'(m_valid), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("out_count", 32'(out_cnt), 32'(NP));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("start_count", 32'(start_cnt), 32'(start_exp));
        chk("err_len_count", 32'(errlen_cnt), 32'(errlen_exp));
        if (!bp_mode) chk("out_burst", 32'(last_cyc - first_cyc), 32'(NP - 1));
        $display("frame %0d: in=%0d out=%0d", fid, NP, out_cnt);
        out_cnt = 0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin : main
        int  n;
        logic any_to;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;

        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("s_ready_after_reset", 32'(s_ready), 32'd1);

        // Frame 1: pixels 0..80, free-flowing output.
        send_frame(8'd0, 8'd1, 0, 1'b0);
        wait_drain(1);

        // Frame 2: output backpressure 1,0,0,1.
        bp_mode = 1'b1;
        send_frame(8'd0, 8'd1, 0, 1'b0);
        wait_drain(2);
        bp_mode = 1'b0;

        // Frame 3: input valid every third cycle.
        send_frame(8'd7, 8'd3, 2, 1'b0);
        wait_drain(3);

        // Frame 4: s_last on pixel 40 and not on pixel 80.
        send_frame(8'd200, 8'd5, 0, 1'b1);
        wait_drain(4);

        // Frame 5: stale done from frame 4 is still high entering WAIT.
        stub_delay = 20;
        chk("stale_done_high", 32'(conv_done), 32'd1);
        send_frame(8'd33, 8'd11, 0, 1'b0);
        wait_drain(5);
        stub_delay = 50;

        // Frame 6: engine never answers.
        stub_never = 1'b1;
        send_frame(8'd90, 8'd2, 0, 1'b0);
`ifdef CONV_BRIDGE_TIMEOUT_EN
        n = 0;
        while (!err_timeout && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycle", cyc, hs_cyc + 1 + TO);
        @(negedge clk);
        chk("timeout_pulse_width", 32'(err_timeout), 32'd0);
        chk("timeout_s_ready", 32'(s_ready), 32'd1);
        chk("timeout_busy", 32'(busy), 32'd0);
        chk("timeout_no_output", 32'(out_cnt), 32'd0);
`else
        any_to = 1'b0;
        repeat (150) begin
            @(negedge clk);
            any_to = any_to | err_timeout;
        end
        chk("no_timeout_built", 32'(any_to), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_no_output", 32'(out_cnt), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif
        exp_q.delete();
        out_cnt    = 0;
        stub_never = 1'b0;
        $display("frame 6: in=%0d out=0 (no engine answer)", NP);

        // Frame 7: reset during byte 30 of DRAIN.
        send_frame(8'd5, 8'd7, 0, 1'b0);
        n = 0;
        while (out_cnt < 30 && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("reach_byte30", 32'(out_cnt), 32'd30);
        rst = 1'b1;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check_idle_zero("mid_reset");
        rst = 1'b0;
        exp_q.delete();
        out_cnt = 0;
        @(negedge clk);
        chk("s_ready_after_mid_reset", 32'(s_ready), 32'd1);
        $display("frame 7: in=%0d out=30 (reset in drain)", NP);

        // Frame 8: clean frame after the abort.
        send_frame(8'd250, 8'd13, 0, 1'b0);
        wait_drain(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
